// File: rtl/acc_cpu_core.sv
// Multi-cycle register CPU core: IDLE/FETCH/EXEC/MEM/WB sequencer with a synchronous data RAM.
// Define ACC_CPU_MUL_EN to make opcode 10 a multiply; otherwise opcode 10 is illegal.
module acc_cpu_core #(
  parameter int unsigned DW     = 8,
  parameter int unsigned MEM_AW = 4,
  parameter int unsigned NREG   = 8
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [15:0]   instr,
  input  logic          instr_vld,
  output logic          instr_rdy,
  output logic          res_vld,
  output logic [2:0]    res_rd,
  output logic [DW-1:0] res_data,
  output logic          retire,
  output logic          flag_z,
  output logic          flag_c,
  output logic          err,
  output logic [15:0]   icount
);

  if (NREG != 8) begin : g_bad_nreg
    $error("acc_cpu_core: NREG must be 8");
  end

`ifdef ACC_CPU_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  localparam logic [3:0] OpLdi = 4'd0;
  localparam logic [3:0] OpMov = 4'd1;
  localparam logic [3:0] OpAdd = 4'd2;
  localparam logic [3:0] OpSub = 4'd3;
  localparam logic [3:0] OpAnd = 4'd4;
  localparam logic [3:0] OpOr  = 4'd5;
  localparam logic [3:0] OpSrl = 4'd6;
  localparam logic [3:0] OpLd  = 4'd7;
  localparam logic [3:0] OpSt  = 4'd8;
  localparam logic [3:0] OpNop = 4'd9;
  localparam logic [3:0] OpMul = 4'd10;

  typedef enum logic [2:0] {StIdle, StFetch, StExec, StMem, StWb} state_e;

  state_e          state_q, state_d;
  logic [15:0]     ir_q;
  logic [DW-1:0]   rf_q [NREG];
  logic [DW-1:0]   a_q, b_q, res_q, rdata_q;
  logic            c_pend_q;
  logic            flag_z_q, flag_c_q, err_q;
  logic [15:0]     icount_q;
  logic [DW-1:0]   mem_q [2**MEM_AW];

  logic [3:0]      op;
  logic [2:0]      rd, rs1, rs2;
  logic            writes_rd, upd_c, illegal;
  logic [DW:0]     sum, diff;
  logic [DW-1:0]   alu_res;
  logic            alu_c;
  logic [MEM_AW-1:0] mem_addr;
`ifdef ACC_CPU_MUL_EN
  logic [2*DW-1:0] prod;
`endif

  assign op       = ir_q[15:12];
  assign rd       = ir_q[11:9];
  assign rs1      = ir_q[8:6];
  assign rs2      = ir_q[5:3];
  assign mem_addr = a_q[MEM_AW-1:0];

  always_comb begin
    writes_rd = (op <= OpLd);
    upd_c     = (op == OpAdd) || (op == OpSub);
    illegal   = (op > OpNop);
    if (MulEn && (op == OpMul)) begin
      writes_rd = 1'b1;
      upd_c     = 1'b1;
      illegal   = 1'b0;
    end
  end

  always_comb begin
    sum     = {1'b0, a_q} + {1'b0, b_q};
    diff    = {1'b0, a_q} - {1'b0, b_q};
    alu_res = '0;
    alu_c   = 1'b0;
`ifdef ACC_CPU_MUL_EN
    prod    = {{DW{1'b0}}, a_q} * {{DW{1'b0}}, b_q};
`endif
    case (op)
      OpLdi: alu_res = DW'($signed(ir_q[7:0]));
      OpMov: alu_res = a_q;
      OpAdd: begin
        alu_res = sum[DW-1:0];
        alu_c   = sum[DW];
      end
      // The extra top bit of the difference is the unsigned borrow.
      OpSub: begin
        alu_res = diff[DW-1:0];
        alu_c   = diff[DW];
      end
      OpAnd: alu_res = a_q & b_q;
      OpOr:  alu_res = a_q | b_q;
      OpSrl: alu_res = (32'(b_q) >= DW) ? '0 : (a_q >> b_q);
`ifdef ACC_CPU_MUL_EN
      OpMul: begin
        alu_res = prod[DW-1:0];
        alu_c   = |prod[2*DW-1:DW];
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (instr_vld) state_d = StFetch;
      StFetch: state_d = StExec;
      StExec:  state_d = (op == OpLd) ? StMem : StWb;
      StMem:   state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= StIdle;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      c_pend_q <= 1'b0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
      err_q    <= 1'b0;
      icount_q <= '0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle:  if (instr_vld) ir_q <= instr;
        // Operands are latched before any write-back, so rd==rs needs no bypass.
        StFetch: begin
          a_q <= rf_q[rs1];
          b_q <= rf_q[rs2];
        end
        StExec: begin
          res_q    <= alu_res;
          c_pend_q <= alu_c;
        end
        StMem:   res_q <= rdata_q;
        StWb: begin
          if (writes_rd) begin
            rf_q[rd] <= res_q;
            flag_z_q <= (res_q == '0);
          end
          if (upd_c) flag_c_q <= c_pend_q;
          if (illegal) err_q <= 1'b1;
          icount_q <= icount_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // RAM is not reset; state_q returns to idle on reset, which blocks any pending store.
  always_ff @(posedge CLK) begin
    if (state_q == StExec) begin
      if (op == OpSt) mem_q[mem_addr] <= b_q;
      rdata_q <= mem_q[mem_addr];
    end
  end

  assign instr_rdy = (state_q == StIdle);
  assign retire    = (state_q == StWb);
  assign res_vld   = (state_q == StWb) && writes_rd;
  assign res_rd    = rd;
  assign res_data  = res_q;
  assign flag_z    = flag_z_q;
  assign flag_c    = flag_c_q;
  assign err       = err_q;
  assign icount    = icount_q;

endmodule

// File: tb/tb_acc_cpu_core.sv
// Self-checking bench for acc_cpu_core: directed vector table, reset/handshake sequences,
// and random instructions against a behavioural model.
module tb_acc_cpu_core;
  localparam int unsigned DW     = 8;
  localparam int unsigned MEM_AW = 4;
  localparam int          MOD    = 1 << DW;
  localparam int          MEMD   = 1 << MEM_AW;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic [15:0]   instr = '0;
  logic          instr_vld = 1'b0;
  logic          instr_rdy, res_vld, retire, flag_z, flag_c, err;
  logic [2:0]    res_rd;
  logic [DW-1:0] res_data;
  logic [15:0]   icount;

  acc_cpu_core #(.DW(DW), .MEM_AW(MEM_AW), .NREG(8)) dut (
    .CLK(CLK), .RESET(RESET), .instr(instr), .instr_vld(instr_vld), .instr_rdy(instr_rdy),
    .res_vld(res_vld), .res_rd(res_rd), .res_data(res_data), .retire(retire),
    .flag_z(flag_z), .flag_c(flag_c), .err(err), .icount(icount)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;

  int m_reg [8];
  int m_mem [MEMD];
  bit m_z, m_c, m_err;
  int m_icount;

  typedef struct {
    logic [15:0] ins;
    bit          vld;
    int          data;
    bit          z;
    bit          c;
    bit          e;
    int          lat;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic add(input logic [15:0] ins, input bit vld, input int data, input bit z,
                     input bit c, input bit e, input int lat);
    vec_t v;
    v.ins = ins; v.vld = vld; v.data = data; v.z = z; v.c = c; v.e = e; v.lat = lat;
    vt.push_back(v);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 0;
    m_z = 0; m_c = 0; m_err = 0; m_icount = 0;
  endtask

  // Architectural effect of one instruction, straight from the opcode table.
  task automatic model_exec(input logic [15:0] ins, output bit ev, output int ed,
                            output int elat);
    int op, rd, s1, s2, a, b, imm, r;
    longint p;
    op = int'(ins[15:12]); rd = int'(ins[11:9]); s1 = int'(ins[8:6]); s2 = int'(ins[5:3]);
    imm = int'(ins[7:0]);
    a = m_reg[s1]; b = m_reg[s2];
    ev = 1; elat = 2; r = 0;
    case (op)
      0: r = (imm >= 128) ? (MOD - 256 + imm) : imm;
      1: r = a;
      2: begin r = (a + b) % MOD; m_c = (a + b) >= MOD; end
      3: begin r = (a - b + MOD) % MOD; m_c = (a < b); end
      4: r = a & b;
      5: r = a | b;
      6: r = (b >= DW) ? 0 : a / (1 << b);
      7: begin r = m_mem[a % MEMD]; elat = 3; end
      8: begin m_mem[a % MEMD] = b; ev = 0; end
      9: ev = 0;
      default: begin
`ifdef ACC_CPU_MUL_EN
        if (op == 10) begin
          p = longint'(a) * longint'(b);
          r = int'(p % MOD);
          m_c = (p / MOD) != 0;
        end else begin
          ev = 0; m_err = 1;
        end
`else
        ev = 0; m_err = 1;
`endif
      end
    endcase
    if (ev) begin
      m_reg[rd] = r;
      m_z = (r == 0);
    end
    m_icount = (m_icount + 1) % 65536;
    ed = r;
  endtask

  // Issue one instruction; returns retire latency (0 = never) and write-back info.
  task automatic run(input logic [15:0] ins, output bit gv, output logic [DW-1:0] gd,
                     output logic [2:0] grd, output int glat);
    int k;
    k = 0;
    while (!instr_rdy && k < 20) begin
      @(posedge CLK); #1; k++;
    end
    chk("instr_rdy_before_issue", instr_rdy, 1);
    @(negedge CLK);
    instr = ins; instr_vld = 1'b1;
    @(posedge CLK); #1;
    instr_vld = 1'b0;
    gv = 0; gd = '0; grd = '0; glat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge CLK); #1;
      if (retire) begin
        glat = i; gv = res_vld; gd = res_data; grd = res_rd;
        break;
      end
    end
    @(posedge CLK); #1;
  endtask

  task automatic step(input logic [15:0] ins);
    bit ev, gv;
    int ed, el, gl;
    logic [DW-1:0] gd;
    logic [2:0] grd;
    model_exec(ins, ev, ed, el);
    run(ins, gv, gd, grd, gl);
    chk($sformatf("latency[%h]", ins), gl, el);
    chk($sformatf("res_vld[%h]", ins), gv, ev);
    if (ev) begin
      chk($sformatf("res_data[%h]", ins), gd, ed);
      chk($sformatf("res_rd[%h]", ins), grd, ins[11:9]);
    end
    chk($sformatf("flag_z[%h]", ins), flag_z, m_z);
    chk($sformatf("flag_c[%h]", ins), flag_c, m_c);
    chk($sformatf("err[%h]", ins), err, m_err);
    chk($sformatf("icount[%h]", ins), icount, m_icount);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit gv, e9, seen;
    logic [DW-1:0] gd, hold_data;
    logic [2:0] grd;
    int gl, nret, busy_rdy;
    bit ev;
    int ed, el;
    logic [3:0] op;

`ifdef ACC_CPU_MUL_EN
    e9 = 0;
`else
    e9 = 1;
`endif
    add(16'h0205, 1, 'h05, 0, 0, 0, 2);       // LDI r1,5
    add(16'h04FB, 1, 'hFB, 0, 0, 0, 2);       // LDI r2,0xFB
    add(16'h2650, 1, 'h00, 1, 1, 0, 2);       // ADD r3,r1,r2
    add(16'h3850, 1, 'h0A, 0, 1, 0, 2);       // SUB r4,r1,r2
    add(16'h6A88, 1, 'h07, 0, 1, 0, 2);       // SRL r5,r2,r1
    add(16'h0E09, 1, 'h09, 0, 1, 0, 2);       // LDI r7,9
    add(16'h6AB8, 1, 'h00, 1, 1, 0, 2);       // SRL r5,r2,r7 (shift >= DW)
    add(16'h8050, 0, 0,     1, 1, 0, 2);      // ST mem[r1]=r2
    add(16'h7C40, 1, 'hFB, 0, 1, 0, 3);       // LD r6,[r1]
`ifdef ACC_CPU_MUL_EN
    add(16'hA650, 1, 'hE7, 0, 1, 0, 2);       // MUL r3,r1,r2
`else
    add(16'hA650, 0, 0,     0, 1, 1, 2);      // illegal
`endif
    add(16'h0215, 1, 'h15, 0, 1, e9, 2);      // LDI r1,0x15
    add(16'h7C40, 1, 'hFB, 0, 1, e9, 3);      // LD r6,[r1] aliases to 5
    add(16'h9000, 0, 0,     0, 1, e9, 2);     // NOP
    add(16'hF000, 0, 0,     0, 1, 1, 2);      // illegal
    add(16'h1080, 1, 'hFB, 0, 1, 1, 2);       // MOV r0,r2
    add(16'h3090, 1, 'h00, 1, 0, 1, 2);       // SUB r0,r2,r2
`ifdef ACC_CPU_MUL_EN
    add(16'h18C0, 1, 'hE7, 0, 0, 1, 2);       // MOV r4,r3
`else
    add(16'h18C0, 1, 'h00, 1, 0, 1, 2);       // MOV r4,r3 (r3 untouched)
`endif

    repeat (3) @(posedge CLK);
    @(negedge CLK) RESET = 1'b0;
    #1;
    chk("reset_instr_rdy", instr_rdy, 1);
    chk("reset_res_vld", res_vld, 0);
    chk("reset_retire", retire, 0);
    chk("reset_res_rd", res_rd, 0);
    chk("reset_res_data", res_data, 0);
    chk("reset_flag_z", flag_z, 0);
    chk("reset_flag_c", flag_c, 0);
    chk("reset_err", err, 0);
    chk("reset_icount", icount, 0);

    for (int i = 0; i < vt.size(); i++) begin
      run(vt[i].ins, gv, gd, grd, gl);
      chk($sformatf("vec%0d_latency", i), gl, vt[i].lat);
      chk($sformatf("vec%0d_res_vld", i), gv, vt[i].vld);
      if (vt[i].vld) begin
        chk($sformatf("vec%0d_res_data", i), gd, vt[i].data);
        chk($sformatf("vec%0d_res_rd", i), grd, vt[i].ins[11:9]);
      end
      chk($sformatf("vec%0d_flag_z", i), flag_z, vt[i].z);
      chk($sformatf("vec%0d_flag_c", i), flag_c, vt[i].c);
      chk($sformatf("vec%0d_err", i), err, vt[i].e);
      chk($sformatf("vec%0d_icount", i), icount, i + 1);
    end

    // Reset while an LD sits in MEM.
    @(negedge CLK);
    instr = 16'h7C40; instr_vld = 1'b1;
    @(posedge CLK); #1;
    instr_vld = 1'b0;
    @(posedge CLK); @(posedge CLK); #1;
    chk("ld_busy_in_mem", instr_rdy, 0);
    RESET = 1'b1;
    seen = 0;
    repeat (3) begin
      @(posedge CLK); #1;
      if (res_vld || retire) seen = 1;
    end
    chk("abort_no_writeback", seen, 0);
    @(negedge CLK) RESET = 1'b0;
    #1;
    chk("abort_instr_rdy", instr_rdy, 1);
    chk("abort_icount", icount, 0);
    chk("abort_err", err, 0);
    chk("abort_flag_z", flag_z, 0);
    chk("abort_flag_c", flag_c, 0);
    model_reset();
    for (int r = 0; r < 8; r++) step({4'h1, 3'd7, 3'(r), 6'd0});   // MOV r7,rN reads 0

    // Hold instr_vld through the whole instruction: exactly one accept.
    @(negedge CLK);
    instr = 16'h0233; instr_vld = 1'b1;
    model_exec(16'h0233, ev, ed, el);
    @(posedge CLK); #1;
    busy_rdy = 0; nret = 0; hold_data = '0;
    repeat (3) begin
      if (instr_rdy) busy_rdy++;
      if (retire) begin
        nret++; hold_data = res_data;
      end
      @(posedge CLK); #1;
    end
    instr_vld = 1'b0;
    repeat (4) begin
      if (retire) nret++;
      @(posedge CLK); #1;
    end
    chk("hold_busy_rdy", busy_rdy, 0);
    chk("hold_retire_count", nret, 1);
    chk("hold_res_data", hold_data, ed);
    chk("hold_icount", icount, m_icount);

    // Give every RAM word a known value, then random instructions.
    for (int a = 0; a < MEMD; a++) begin
      step({4'h0, 3'd1, 1'b0, 8'(a)});
      step({4'h0, 3'd2, 1'b0, 8'($urandom)});
      step({4'h8, 3'd0, 3'd1, 3'd2, 3'd0});
    end
    for (int n = 0; n < 250; n++) begin
      op = 4'($urandom_range(0, 15));
      if (op >= 4'd10 && $urandom_range(0, 3) != 0) op = 4'($urandom_range(0, 9));
      step({op, 12'($urandom)});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
